reg_unload: RTL and testbench
=============================

Name: reg_unload

Overview:
- Read-side counterpart of the per-thread BRAM register file. The register file is loaded from memory; this block streams a thread's registers back out to memory or the output path.
- On a start command it walks a contiguous, wrapping range of one thread's 16 registers. It drives the file's two-stage read port (rd_en0 address/BRAM stage, rd_en1 output-flop stage) and buffers the returned words in a small FIFO.
- It presents the words on a valid/ready stream with a last flag.
- It sits beside the CPU on the register file read port and shares that port through a request/grant pair.

Parameters:
- WIDTH, 16, register word width.
- N_THREADS, 6, number of thread contexts in the register file.
- N_THREADS_MSB, `MSB(N_THREADS-1), thread number MSB.
- REG_ADDR_MSB, 3, register address MSB (16 registers per thread).
- FIFO_DEPTH, 4, output buffer depth in words; power of 2, minimum 4.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe.
- start_thread_num  in  N_THREADS_MSB+1  thread to unload.
- start_reg_first  in  REG_ADDR_MSB+1  first register address.
- start_count  in  REG_ADDR_MSB+1  number of words minus 1 (0 → 1 word, 15 → 16 words).
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- rd_req  out  1  request for the register file read port.
- rd_grant  in  1  read port granted this cycle.
- rd_addr  out  REG_ADDR_MSB+1  register address to the file.
- rd_thread_num  out  N_THREADS_MSB+1  thread number to the file.
- rd_en0  out  1  file BRAM read enable.
- rd_en1  out  1  file output-flop enable.
- reg_dout  in  WIDTH  file read data.
- out_dat  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  final word of the command.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0) state:
  - FSM goes to IDLE.
  - FIFO is emptied and the in-flight pipeline is cleared.
  - busy, done, rd_req, rd_en0, rd_en1, out_valid and out_last are all 0.
  - out_dat, rd_addr and rd_thread_num are 0.
  - Reset in mid-command abandons the command with no done pulse. Words already issued to the file are discarded.
- FSM states are IDLE, ISSUE, DRAIN and FIN.
- IDLE:
  - start=1 latches thread, address and remaining count (start_count) and moves to ISSUE.
  - busy goes to 1 from the next cycle.
  - start while not IDLE is ignored.
- ISSUE:
  - rd_req=1 whenever credit is available. Credit means FIFO occupancy + in-flight count < FIFO_DEPTH.
  - A read issues in the cycle where rd_req and rd_grant are both 1. That cycle: rd_en0=1, rd_addr = current address, rd_thread_num = latched thread.
  - After an issue, the address increments modulo 16 (wraps within the thread, 15→0) and the remaining count decrements.
  - Once the last word has issued, the FSM moves to DRAIN.
  - rd_req=0 with no credit; no issue then, whatever rd_grant is.
- Read pipeline:
  - Issue at cycle t gives rd_en1=1 at t+1, unconditionally. The external arbiter must leave rd_en1 to this block for the cycle after a grant.
  - reg_dout is valid at t+2 and is written into the FIFO that cycle.
  - A 2-deep valid shift register tracks in-flight reads. At most 2 are in flight.
  - Back-to-back grants give one issue per cycle.
- Output stream:
  - out_valid = FIFO not empty. out_dat is the FIFO head.
  - out_last=1 on the head entry that is the final word of the command; the tag is stored in the FIFO alongside the data.
  - out_dat and out_last stay stable while out_valid=1 and out_ready=0.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- DRAIN: waits until the last-tagged word is popped, then moves to FIN.
- FIN:
  - done=1 for one cycle. busy is still 1 in that cycle.
  - Then IDLE; busy=0 from the next cycle.
  - A start in the same cycle as done is ignored.
- Minimum latency with constant grant and ready: start at cycle 0 gives the first issue at cycle 1 and the first out_valid at cycle 3.
- FIFO overflow cannot occur; the credit scheme guarantees it. An assertion checks this in simulation.

Decomposition:
- Shared include (md5.vh):
  - MSB macro.
  - REG_ADDR_MSB.
  - FSM state encodings for IDLE, ISSUE, DRAIN and FIN.
- One sub-module: reg_unload_fifo.
  - Synchronous, register-based FIFO of width WIDTH+1 (data + last).
  - Outputs: empty/full and occupancy count.
  - Same async active-low reset.

Test Plan:
- Single word: thread 2, first=5, count=0, grant=1, ready=1, file preloaded with reg[2][5]=16'hA5A5. Required: one rd_en0 with rd_addr=5 and rd_thread_num=2; out_dat=A5A5 with out_valid=1 and out_last=1 at cycle 3; done one cycle after the accept.
- Full thread with wrap: thread 5, first=12, count=15, reg[n]=16'h5000+n. Required: addresses 12,13,14,15,0,…,11 in order; 16 words out, one per cycle after fill; out_last only on 16'h500B.
- Backpressure: same as above but out_ready=0 for 20 cycles. Required: exactly FIFO_DEPTH reads issue, then rd_req=0; out_dat holds 16'h500C. After ready=1, all data arrives in order with no loss or duplication.
- Grant gaps: rd_grant toggled 1,0,0,1,1,0…. Required: rd_en0 only on granted cycles; rd_en1 exactly one cycle after each rd_en0; output order unchanged.
- Reset mid-command: rst_n pulsed low after 3 words issued. Required: out_valid, busy, rd_req and done go to 0 immediately with no done pulse. A new start afterwards unloads correctly.
- Start while busy: a second start during ISSUE with a different thread. Required: ignored; only the first command's words are output.

Source files
------------

// File: rtl/reg_unload_pkg.sv
// Shared definitions for the register-file unload block: FSM encoding,
// default register address width and a small MSB helper for parameter math.
package reg_unload_pkg;

   // 16 registers per thread -> 4-bit register address.
   localparam int DEF_REG_ADDR_MSB = 3;

   // Command FSM.
   //   ST_IDLE  : waiting for start
   //   ST_ISSUE : issuing reads while credit allows
   //   ST_DRAIN : all reads issued, waiting for the last word to leave
   //   ST_FIN   : one-cycle done pulse
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // Index of the highest set bit of value (0 for value <= 1).
   // Used to size thread-number ports from a thread count.
   function automatic int msb_of(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if (value[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_unload_fifo.sv
// Register-based synchronous FIFO holding {last, data} words on their way
// from the register file to the output stream. Push and pop may occur in the
// same cycle at any occupancy, including full.
module reg_unload_fifo #(
   parameter  int W     = 17,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot in the same cycle, so push-while-full is legal
   // only when accompanied by a pop.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rd_ptr];

   // Storage write; cleared on reset so the head reads zero when empty.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The issuing side's credit scheme must make an unaccompanied push into a
   // full FIFO impossible.
   a_no_overflow: assert property (@(posedge CLK) disable iff (!rst_n)
      !(push && full && !pop));

endmodule

// File: rtl/reg_unload.sv
// Streams a contiguous, wrapping range of one thread's registers out of the
// BRAM register file. Reads go through the file's two-stage read port
// (rd_en0 = BRAM stage, rd_en1 = output-flop stage); returned words land in
// a small FIFO that feeds a valid/ready stream tagged with a last flag.
//
// Handshakes:
//   rd_req/rd_grant : a read issues in any cycle where both are 1.
//   out_valid/out_ready : a word transfers in any cycle where both are 1;
//                         out_dat/out_last hold while valid and not ready.
module reg_unload
   import reg_unload_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int N_THREADS     = 6,
   parameter int N_THREADS_MSB = msb_of(N_THREADS - 1),
   parameter int REG_ADDR_MSB  = DEF_REG_ADDR_MSB,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [N_THREADS_MSB:0]   start_thread_num,
   input  logic [REG_ADDR_MSB:0]    start_reg_first,
   input  logic [REG_ADDR_MSB:0]    start_count,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_req,
   input  logic                     rd_grant,
   output logic [REG_ADDR_MSB:0]    rd_addr,
   output logic [N_THREADS_MSB:0]   rd_thread_num,
   output logic                     rd_en0,
   output logic                     rd_en1,
   input  logic [WIDTH-1:0]         reg_dout,
   output logic [WIDTH-1:0]         out_dat,
   output logic                     out_valid,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                   state;
   state_t                   state_nxt;

   // Latched command.
   logic [N_THREADS_MSB:0]   thr_q;
   logic [REG_ADDR_MSB:0]    addr_q;
   logic [REG_ADDR_MSB:0]    rem_q;

   // In-flight read tracking: stage 1 = rd_en1 cycle, stage 2 = data cycle.
   logic                     v1_q;
   logic                     v2_q;
   logic                     l1_q;
   logic                     l2_q;

   logic                     issue;
   logic                     issue_last;
   logic                     credit;
   logic [CW:0]              reserved;

   logic                     fifo_pop;
   logic [WIDTH:0]           fifo_head;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic [CW-1:0]            fifo_count;

   // Slots already spoken for: words in the FIFO plus reads still in flight.
   // Pops in the current cycle are not counted, which keeps this conservative.
   assign reserved   = {1'b0, fifo_count} + (CW+1)'(v1_q) + (CW+1)'(v2_q);
   assign credit     = ~fifo_full & (reserved < (CW+1)'(FIFO_DEPTH));
   assign issue_last = (rem_q == '0);
   assign issue      = rd_req & rd_grant;

   assign rd_en0        = issue;
   assign rd_en1        = v1_q;
   assign rd_addr       = addr_q;
   assign rd_thread_num = thr_q;

   assign fifo_pop  = out_valid & out_ready;
   assign out_valid = ~fifo_empty;
   assign out_dat   = fifo_head[WIDTH-1:0];
   assign out_last  = ~fifo_empty & fifo_head[WIDTH];

   // FSM state register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state and control outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      rd_req    = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            rd_req = credit;
            if (credit && rd_grant && issue_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_pop && fifo_head[WIDTH]) state_nxt = ST_FIN;
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command registers: latch on an accepted start, walk on each issue.
   // The address is REG_ADDR_MSB+1 bits wide, so the increment wraps 15 -> 0
   // inside the same thread.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         thr_q  <= '0;
         addr_q <= '0;
         rem_q  <= '0;
      end else if (state == ST_IDLE && start) begin
         thr_q  <= start_thread_num;
         addr_q <= start_reg_first;
         rem_q  <= start_count;
      end else if (issue) begin
         addr_q <= addr_q + 1'b1;
         rem_q  <= rem_q - 1'b1;
      end
   end

   // Two-deep valid/last shift register following each issued read through
   // the file's BRAM and output-flop stages.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         l1_q <= 1'b0;
         l2_q <= 1'b0;
      end else begin
         v1_q <= issue;
         l1_q <= issue & issue_last;
         v2_q <= v1_q;
         l2_q <= l1_q;
      end
   end

   reg_unload_fifo #(
      .W     (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .push     (v2_q),
      .push_dat ({l2_q, reg_dout}),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_reg_unload.sv
// Bench for reg_unload: behavioural register file, table of unload commands
// with a scoreboard on issued addresses and streamed words, plus hand-written
// sequences for latency, reset mid-command and start-while-busy.
module tb_reg_unload;

   localparam int WIDTH      = 16;
   localparam int FIFO_DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst_n;
   int          cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        start;
   logic [2:0]  start_thread_num;
   logic [3:0]  start_reg_first;
   logic [3:0]  start_count;
   logic        busy, done, rd_req, rd_grant, rd_en0, rd_en1;
   logic [3:0]  rd_addr;
   logic [2:0]  rd_thread_num;
   logic [15:0] reg_dout, out_dat;
   logic        out_valid, out_last, out_ready;

   reg_unload dut (
      .CLK              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .start_thread_num (start_thread_num),
      .start_reg_first  (start_reg_first),
      .start_count      (start_count),
      .busy             (busy),
      .done             (done),
      .rd_req           (rd_req),
      .rd_grant         (rd_grant),
      .rd_addr          (rd_addr),
      .rd_thread_num    (rd_thread_num),
      .rd_en0           (rd_en0),
      .rd_en1           (rd_en1),
      .reg_dout         (reg_dout),
      .out_dat          (out_dat),
      .out_valid        (out_valid),
      .out_last         (out_last),
      .out_ready        (out_ready)
   );

   // ---------------- register file model ----------------
   logic [15:0] mem [6][16];
   logic [15:0] bram_q;

   always @(posedge clk) begin
      if (rd_en0) bram_q <= mem[rd_thread_num][rd_addr];
      if (rd_en1) reg_dout <= bram_q;
   end

   // ---------------- counters / scoreboard ----------------
   int          n_checks;
   int          n_bad;
   logic [16:0] exp_q[$];      // {last, data}
   logic [6:0]  exp_a_q[$];    // {thread, addr}
   int          issue_cnt;
   int          accepted;
   int          first_acc_cyc;
   int          last_acc_cyc;
   logic [15:0] last_word;
   logic        done_seen;
   logic        done_exp;
   logic        prev_en0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- grant / ready drivers ----------------
   int   grant_mode;   // 0 constant, 1 pattern 1,0,0,1,1,0, 2 random
   int   ready_mode;   // 0 constant, 1 random
   logic ready_hold;
   logic gpat [6];
   int   gidx;

   initial begin
      gpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      gidx = 0;
      forever begin
         @(posedge clk);
         #1;
         case (grant_mode)
            0: rd_grant = 1'b1;
            1: begin
               rd_grant = gpat[gidx];
               gidx = (gidx + 1) % 6;
            end
            default: rd_grant = 1'($urandom_range(0, 1));
         endcase
         if (ready_hold)      out_ready = 1'b0;
         else if (ready_mode) out_ready = 1'($urandom_range(0, 1));
         else                 out_ready = 1'b1;
      end
   end

   // ---------------- monitor (sampled on the falling edge) ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en0 = 1'b0;
         done_exp = 1'b0;
      end else begin
         logic [16:0] e;
         logic [6:0]  ea;
         if (rd_en1 || prev_en0) chk("rd_en1_follow", 32'(rd_en1), 32'(prev_en0));
         prev_en0 = rd_en0;
         if (rd_en0) begin
            issue_cnt++;
            chk("en0_granted", 32'(rd_req && rd_grant), 32'd1);
            if (exp_a_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
            else begin
               ea = exp_a_q.pop_front();
               chk("rd_addr", 32'(rd_addr), 32'(ea[3:0]));
               chk("rd_thread", 32'(rd_thread_num), 32'(ea[6:4]));
            end
         end
         if (done || done_exp) chk("done_pulse", 32'(done), 32'(done_exp));
         if (done) begin
            chk("busy_at_done", 32'(busy), 32'd1);
            done_seen = 1'b1;
         end
         done_exp = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(out_dat), 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("out_dat", 32'(out_dat), 32'(e[15:0]));
               chk("out_last", 32'(out_last), 32'(e[16]));
            end
            if (accepted == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            accepted++;
            last_word = out_dat;
            done_exp = out_last;
         end
      end
   end

   // ---------------- command driver ----------------
   task automatic push_expect(input int thr, input int first, input int cnt);
      for (int i = 0; i <= cnt; i++) begin
         logic [3:0] a;
         a = 4'((first + i) % 16);
         exp_q.push_back({(i == cnt), mem[thr][a]});
         exp_a_q.push_back({3'(thr), a});
      end
   endtask

   task automatic send_start(input int thr, input int first, input int cnt, input bit expect_it);
      @(posedge clk);
      #1;
      if (expect_it) begin
         push_expect(thr, first, cnt);
         issue_cnt = 0;
         accepted  = 0;
         done_seen = 1'b0;
      end
      start            = 1'b1;
      start_thread_num = 3'(thr);
      start_reg_first  = 4'(first);
      start_count      = 4'(cnt);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < 600 && !done_seen; k++) @(posedge clk);
      if (!done_seen) chk({name, "_done_timeout"}, 32'd0, 32'd1);
      #1;
      chk({name, "_busy_after"}, 32'(busy), 32'd0);
      chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   typedef struct {
      int          thr;
      int          first;
      int          cnt;
      int          gmode;
      int          rmode;
      int          stall;
      int          n_exp;
      logic [15:0] last_exp;
   } cmd_t;

   cmd_t cmds [7];

   initial begin
      n_checks = 0; n_bad = 0; issue_cnt = 0; accepted = 0;
      done_seen = 0; done_exp = 0; prev_en0 = 0;
      grant_mode = 0; ready_mode = 0; ready_hold = 0;
      rst_n = 1'b0; start = 1'b0; start_thread_num = '0;
      start_reg_first = '0; start_count = '0; rd_grant = 1'b0; out_ready = 1'b0;
      reg_dout = '0; bram_q = '0;

      for (int t = 0; t < 6; t++)
         for (int r = 0; r < 16; r++)
            mem[t][r] = 16'(t * 16'h1000 + 16'h0A00 + r);
      for (int r = 0; r < 16; r++) mem[5][r] = 16'(16'h5000 + r);
      mem[2][5] = 16'hA5A5;

      //               thr first cnt gm rm stall n  last
      cmds[0] = '{2,   5,   0,  0, 0, 0,   1, 16'hA5A5};
      cmds[1] = '{5,  12,  15,  0, 0, 0,  16, 16'h500B};
      cmds[2] = '{5,  12,  15,  0, 0, 20, 16, 16'h500B};
      cmds[3] = '{5,  12,  15,  1, 0, 0,  16, 16'h500B};
      cmds[4] = '{3,  14,   3,  2, 1, 0,   4, 16'h3A01};
      cmds[5] = '{0,   0,  15,  2, 1, 0,  16, 16'h0A0F};
      cmds[6] = '{1,   9,   6,  1, 1, 0,   7, 16'h1A0F};

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_req", 32'(rd_req), 0);
      chk("rst_en", 32'({rd_en0, rd_en1}), 0);
      chk("rst_out", 32'({out_valid, out_last}), 0);
      chk("rst_dat_addr", 32'({out_dat, rd_addr, rd_thread_num}), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Latency: start sampled at edge 0, issue at edge 1, word visible after edge 3.
      send_start(2, 5, 0, 1'b1);
      chk("lat_en0", 32'(rd_en0), 1);
      chk("lat_busy", 32'(busy), 1);
      @(posedge clk); #1 chk("lat_valid_e1", 32'(out_valid), 0);
      @(posedge clk); #1 chk("lat_valid_e2", 32'(out_valid), 0);
      @(posedge clk); #1 chk("lat_valid_e3", 32'(out_valid), 1);
      chk("lat_dat", 32'(out_dat), 32'h0000_A5A5);
      chk("lat_last", 32'(out_last), 1);
      wait_done("latency");

      // Table of commands.
      for (int i = 0; i < 7; i++) begin
         grant_mode = cmds[i].gmode;
         ready_mode = cmds[i].rmode;
         ready_hold = (cmds[i].stall > 0);
         repeat (2) @(posedge clk);
         send_start(cmds[i].thr, cmds[i].first, cmds[i].cnt, 1'b1);
         if (cmds[i].stall > 0) begin
            repeat (cmds[i].stall - 1) @(posedge clk);
            @(negedge clk);
            chk("stall_issues", 32'(issue_cnt), 32'(FIFO_DEPTH));
            chk("stall_rd_req", 32'(rd_req), 0);
            chk("stall_head", 32'(out_dat), 32'h0000_500C);
            chk("stall_valid", 32'(out_valid), 1);
            ready_hold = 1'b0;
         end
         wait_done($sformatf("cmd%0d", i));
         chk($sformatf("cmd%0d_words", i), 32'(accepted), 32'(cmds[i].n_exp));
         chk($sformatf("cmd%0d_lastword", i), 32'(last_word), 32'(cmds[i].last_exp));
         if (cmds[i].gmode == 0 && cmds[i].rmode == 0 && cmds[i].stall == 0 && cmds[i].n_exp > 1)
            chk($sformatf("cmd%0d_rate", i), 32'(last_acc_cyc - first_acc_cyc), 32'(cmds[i].n_exp - 1));
      end

      // Reset in mid-command.
      grant_mode = 0; ready_mode = 0; ready_hold = 0;
      repeat (2) @(posedge clk);
      send_start(4, 0, 15, 1'b1);
      for (int k = 0; k < 100 && issue_cnt < 3; k++) begin
         @(negedge clk);
         #1;
      end
      chk("rst_mid_issued", 32'(issue_cnt), 3);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_rd_req", 32'(rd_req), 0);
      chk("rst_mid_done", 32'(done), 0);
      exp_q.delete();
      exp_a_q.delete();
      done_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("rst_mid_no_done", 32'(done_seen), 0);
      send_start(5, 12, 15, 1'b1);
      wait_done("after_reset");
      chk("after_reset_words", 32'(accepted), 16);

      // Start while busy is ignored.
      repeat (2) @(posedge clk);
      send_start(0, 3, 7, 1'b1);
      @(posedge clk);
      send_start(1, 0, 2, 1'b0);
      wait_done("busy_start");
      chk("busy_start_words", 32'(accepted), 8);
      repeat (10) @(posedge clk);
      #1;
      chk("busy_start_idle", 32'({busy, out_valid}), 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
